// File: rtl/alu_seq_if.sv
// Operand/result channel of alu_seq: an issue side (in_valid/in_ready with
// a, b, op) and a result side (out_valid/out_ready with result, flags).
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    // Producer/consumer side: issues operations and takes results.
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, flags
    );

    // ALU side.
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked, WIDTH-generic ALU with an iterative shift-add multiplier.
// Handshake: an operation is taken on a clock edge where in_valid && in_ready;
// a result is taken on an edge where out_valid && out_ready. Only one operation
// is in flight; in_ready is high only in IDLE and out_valid only in DONE.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus,
    output logic [1:0] state_dbg
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       mcand;
    logic [2*WIDTH-1:0]     prod;
    logic [2*WIDTH-1:0]     prod_step;
    logic [WIDTH:0]         step_sum;
    logic                   last_step;
    logic                   accept;
    logic [WIDTH-1:0]       result_q;
    logic [3:0]             flags_q;

    logic [WIDTH-1:0]       alu_res;
    logic                   alu_c;
    logic                   alu_v;
    logic [WIDTH:0]         add_t;
    logic [WIDTH:0]         sub_t;
    logic [WIDTH:0]         shl_t;
    logic [WIDTH:0]         shr_t;
    logic signed [WIDTH:0]  sar_t;
    logic [WIDTH-1:0]       mul_res;
    logic                   mul_c;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign state_dbg     = state;
    assign accept        = bus.in_valid && (state == IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nxt = (bus.op == 4'd9) ? BUSY : DONE;
            BUSY:    if (last_step) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle ops. The shift temporaries carry one guard bit so the bit
    // shifted out last lands in a fixed position and becomes the carry; large
    // amounts shift everything (including the guard) out naturally.
    always_comb begin
        add_t   = {1'b0, bus.a} + {1'b0, bus.b};
        sub_t   = {1'b0, bus.a} - {1'b0, bus.b};
        shl_t   = {1'b0, bus.a} << bus.b;
        shr_t   = {bus.a, 1'b0} >> bus.b;
        sar_t   = $signed({bus.a, 1'b0}) >>> bus.b;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.op)
            4'd0: begin
                alu_res = add_t[WIDTH-1:0];
                alu_c   = add_t[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (add_t[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd1: begin
                alu_res = sub_t[WIDTH-1:0];
                alu_c   = sub_t[WIDTH];
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (sub_t[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd2: alu_res = bus.a & bus.b;
            4'd3: alu_res = bus.a | bus.b;
            4'd4: alu_res = bus.a ^ bus.b;
            4'd5: alu_res = ~bus.a;
            4'd6: begin
                alu_res = shl_t[WIDTH-1:0];
                alu_c   = shl_t[WIDTH];
            end
            4'd7: begin
                alu_res = shr_t[WIDTH:1];
                alu_c   = shr_t[0];
            end
            4'd8: begin
                alu_res = sar_t[WIDTH:1];
                alu_c   = sar_t[0];
            end
            default: ;
        endcase
    end

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit (prod[0]) is set, then shift the pair right.
    always_comb begin
        step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_step = {step_sum, prod[WIDTH-1:1]};
        last_step = (cnt == CW'(1));
        mul_res   = prod_step[WIDTH-1:0];
        mul_c     = |prod_step[2*WIDTH-1:WIDTH];
    end

    // Operand capture, multiplier iteration and result/flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            mcand    <= '0;
            prod     <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.op == 4'd9) begin
                            mcand <= bus.a;
                            prod  <= {{WIDTH{1'b0}}, bus.b};
                            cnt   <= CW'(WIDTH);
                        end else begin
                            result_q <= alu_res;
                            flags_q  <= {alu_v, alu_c, alu_res[WIDTH-1], alu_res == '0};
                        end
                    end
                end
                BUSY: begin
                    prod <= prod_step;
                    cnt  <= cnt - CW'(1);
                    if (last_step) begin
                        result_q <= mul_res;
                        flags_q  <= {1'b0, mul_c, mul_res[WIDTH-1], mul_res == '0};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
